// File: rtl/query_segment_loader.sv
// query_segment_loader
//   Pops 3-bit query entries {valid, base[1:0]} from the query base FIFO, one
//   per cycle, and groups them into segments of NUM_PE bases for the PE-array
//   controller. An entry with bit 2 clear is the end-of-query marker. It closes
//   the final segment, which may be partial or empty, and flags it as last.
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start_i       begin loading one query (sampled in IDLE only)
//   q_i           FIFO head entry, meaningful while ready_one_i=1
//   ready_one_i   FIFO holds at least one entry
//   update_o      pop FIFO head this cycle (combinational)
//   seg_bases_o   slot k at [3k+2:3k]; unfilled slots read 3'b000
//   seg_cnt_o     valid bases in presented segment
//   seg_last_o    presented segment is the last of the query
//   seg_idx_o     segment index within query, wraps modulo 2^SEG_BIT
//   seg_valid_o   segment presented; seg_ready_i accepts it
//   busy_o        not idle
//   done_o        one-cycle pulse after the last segment is accepted

// One base slot. It is cleared when a query starts or a segment is accepted,
// and it is written when a valid base pop targets this slot.
module query_segment_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       we,
  input  logic [2:0] d,
  output logic [2:0] q
);
  always_ff @(posedge clk) begin
    if (rst || clr) q <= 3'b000;
    else if (we)    q <= d;
  end
endmodule

module query_segment_loader #(
  parameter int NUM_PE  = 4,
  parameter int CNT_BIT = 3,
  parameter int SEG_BIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [2:0]            q_i,
  input  logic                  ready_one_i,
  output logic                  update_o,
  output logic [3*NUM_PE-1:0]   seg_bases_o,
  output logic [CNT_BIT-1:0]    seg_cnt_o,
  output logic                  seg_last_o,
  output logic [SEG_BIT-1:0]    seg_idx_o,
  output logic                  seg_valid_o,
  input  logic                  seg_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD    = 2'd1;
  localparam logic [1:0] PRESENT = 2'd2;

  logic [1:0]                state;
  logic [CNT_BIT-1:0]        fill_cnt;
  logic [CNT_BIT-1:0]        fill_nxt;
  logic [NUM_PE-1:0][2:0]    slots;
  logic [NUM_PE-1:0]         slot_we;
  logic                      slot_clr;
  logic                      accept;

  assign update_o = ~rst & (state == LOAD) & ready_one_i;
  assign accept   = seg_valid_o & seg_ready_i;
  assign fill_nxt = fill_cnt + CNT_BIT'(1);

  // Slots are cleared when a query starts and after each non-last accept.
  // After the last accept they are left alone. The next start clears them.
  assign slot_clr = ((state == IDLE) & start_i) |
                    ((state == PRESENT) & accept & ~seg_last_o);

  genvar k;
  generate
    for (k = 0; k < NUM_PE; k++) begin : g_slot
      // A marker pop (bit 2 clear) never writes a slot.
      assign slot_we[k] = update_o & q_i[2] & (fill_cnt == CNT_BIT'(k));
      query_segment_slot u_slot (
        .clk (clk),
        .rst (rst),
        .clr (slot_clr),
        .we  (slot_we[k]),
        .d   (q_i),
        .q   (slots[k])
      );
    end
  endgenerate

  assign seg_bases_o = slots;
  assign busy_o      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fill_cnt    <= '0;
      seg_cnt_o   <= '0;
      seg_last_o  <= 1'b0;
      seg_idx_o   <= '0;
      seg_valid_o <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state      <= LOAD;
            fill_cnt   <= '0;
            seg_cnt_o  <= '0;
            seg_idx_o  <= '0;
            seg_last_o <= 1'b0;
          end
        end
        LOAD: begin
          if (ready_one_i) begin
            if (q_i[2]) begin
              fill_cnt <= fill_nxt;
              if (fill_nxt == CNT_BIT'(NUM_PE)) begin
                state       <= PRESENT;
                seg_valid_o <= 1'b1;
                seg_last_o  <= 1'b0;
                seg_cnt_o   <= fill_nxt;
              end
            end else begin
              // The marker closes the segment as it stands. This segment
              // may be empty.
              state       <= PRESENT;
              seg_valid_o <= 1'b1;
              seg_last_o  <= 1'b1;
              seg_cnt_o   <= fill_cnt;
            end
          end
        end
        PRESENT: begin
          if (accept) begin
            seg_valid_o <= 1'b0;
            if (seg_last_o) begin
              state  <= IDLE;
              done_o <= 1'b1;
            end else begin
              state     <= LOAD;
              fill_cnt  <= '0;
              seg_cnt_o <= '0;
              seg_idx_o <= seg_idx_o + SEG_BIT'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
